// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational 32-bit ALU among NREQ requesters,
// with one registered response slot per requester and an optional owner lock with timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_ARB     | round-robin among all eligible requesters, starting after rr_ptr
// ST_LOCKED  | only owner may be granted; forced back to ST_ARB after LOCK_MAX idle cycles
module alu_share_arbiter #(
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_out,
  output logic [3*NREQ-1:0]    rsp_flags,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_op,
  input  logic [31:0]          alu_out,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 alu_negative,
  output logic                 lock_timeout
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, owner, gnt_idx, cand;
  logic [CW-1:0]   lock_cnt;
  logic [NREQ-1:0] elig, gnt;
  logic            any_gnt, force_rel;

  // A full slot that is draining this cycle can accept a new result.
  assign elig = req_valid & (~rsp_valid | rsp_ready) & {NREQ{~rst}};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    force_rel = 1'b0;
    case (state)
      ST_ARB: begin
        if (any_gnt && req_lock[gnt_idx]) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (any_gnt) begin
          if (!req_lock[gnt_idx]) state_nxt = ST_ARB;
        end else if (lock_cnt == CNT_LAST) begin
          state_nxt = ST_ARB;
          force_rel = 1'b1;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    if (state == ST_LOCKED) begin
      if (elig[owner]) begin
        gnt[owner] = 1'b1;
        gnt_idx    = owner;
        any_gnt    = 1'b1;
      end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = PW'((int'(rr_ptr) + k) % NREQ);
        if (!any_gnt && elig[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
          any_gnt   = 1'b1;
        end
      end
    end

    req_ready = gnt;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        alu_a  = req_a[i*32 +: 32];
        alu_b  = req_b[i*32 +: 32];
        alu_op = req_op[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= PW'(NREQ - 1);
      owner        <= '0;
      lock_cnt     <= '0;
      rsp_valid    <= '0;
      rsp_out      <= '0;
      rsp_flags    <= '0;
      lock_timeout <= 1'b0;
    end else begin
      lock_timeout <= force_rel;
      if (any_gnt) rr_ptr <= gnt_idx;

      // A refill in the same cycle as a drain keeps the slot full.
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          rsp_out[i*32 +: 32] <= alu_out;
          rsp_flags[i*3 +: 3] <= {alu_zero, alu_overflow, alu_negative};
          rsp_valid[i]        <= 1'b1;
        end else if (rsp_ready[i]) begin
          rsp_valid[i]        <= 1'b0;
        end
      end

      if (any_gnt && req_lock[gnt_idx]) begin
        owner    <= gnt_idx;
        lock_cnt <= '0;
      end else if (state == ST_LOCKED && !any_gnt) begin
        lock_cnt <= force_rel ? '0 : lock_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NREQ=2, LOCK_MAX=16) with a small behavioural ALU
// on the shared port; expected values are hand-computed constants.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDU = 4'h3;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, req_lock, rsp_valid, rsp_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b, rsp_out;
  logic [5:0]  rsp_flags;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_overflow, alu_negative, lock_timeout;
  logic [32:0] sum33;

  int n_vec = 0;
  int n_bad = 0;
  int blocked, pulses;

  alu_share_arbiter #(.NREQ(2), .LOCK_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .lock_timeout(lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sum33        = 33'd0;
    alu_out      = 32'd0;
    alu_overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_out      = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      OP_ADDU: begin
        sum33        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out      = sum33[31:0];
        alu_overflow = sum33[32];
      end
      OP_SUB: begin
        alu_out      = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      default: alu_out = alu_a ^ alu_b;
    endcase
  end
  assign alu_zero     = (alu_out == 32'd0);
  assign alu_negative = alu_out[31];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic lk);
    req_op[i*4 +: 4]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_lock[i]       = lk;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_lock = '0; req_op = '0;
    req_a = '0; req_b = '0; rsp_ready = '0;
    tick; tick;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_out", rsp_out, 64'd0);
    chk("rst_rsp_flags", rsp_flags, 6'd0);
    chk("rst_lock_timeout", lock_timeout, 1'b0);
    chk("idle_alu_a", alu_a, 32'd0);
    rst = 1'b0;

    // T1: single ADD from req0
    set_req(0, OP_ADD, 32'd5, 32'd7, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_alu_ab", {alu_a, alu_b}, {32'd5, 32'd7});
    chk("t1_alu_op", alu_op, OP_ADD);
    tick;
    req_valid = 2'b00;
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_out", rsp_out[31:0], 32'd12);
    chk("t1_flags", rsp_flags[2:0], 3'b000);
    rsp_ready = 2'b11;
    tick;
    chk("t1_drain", rsp_valid, 2'b00);

    // T2: both valid every cycle; rr_ptr=0 so req1 wins first
    set_req(0, OP_ADD, 32'd1, 32'd1, 1'b0);
    set_req(1, OP_ADD, 32'd2, 32'd2, 1'b0);
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t2_alternate", req_ready, (c % 2 == 0) ? 2'b10 : 2'b01);
      tick;
    end
    req_valid = 2'b00;
    chk("t2_rsp_out", rsp_out, {32'd4, 32'd2});
    tick;
    chk("t2_drain", rsp_valid, 2'b00);

    // T3: req1 slot held full, req0 keeps being served
    rsp_ready = 2'b00;
    set_req(1, OP_SUB, 32'd3, 32'd3, 1'b0);
    req_valid = 2'b10;
    #1;
    chk("t3_ready_sub", req_ready, 2'b10);
    tick;
    set_req(1, OP_ADD, 32'd1, 32'd1, 1'b0);
    set_req(0, OP_ADD, 32'd5, 32'd5, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("t3_slot1_full", rsp_valid, 2'b10);
    chk("t3_sub_result", {rsp_out[63:32], 29'd0, rsp_flags[5:3]}, {32'd0, 29'd0, 3'b100});
    chk("t3_req0_served", req_ready, 2'b01);
    tick;
    req_valid = 2'b10;
    #1;
    chk("t3_req1_blocked", req_ready, 2'b00);
    chk("t3_slot1_held", rsp_out[63:32], 32'd0);
    rsp_ready = 2'b10;
    #1;
    chk("t3_drain_regrant", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    chk("t3_refill_valid", rsp_valid[1], 1'b1);
    chk("t3_refill_out", {rsp_out[63:32], 29'd0, rsp_flags[5:3]}, {32'd2, 29'd0, 3'b000});
    rsp_ready = 2'b11;
    tick;
    chk("t3_drain", rsp_valid, 2'b00);

    // T4: locked 64-bit add pair on req0; req1 waits
    set_req(0, OP_ADDU, 32'hFFFF_FFFF, 32'd1, 1'b1);
    set_req(1, OP_ADD, 32'd9, 32'd9, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("t4_lock_grant", req_ready, 2'b01);
    chk("t4_alu_op", alu_op, OP_ADDU);
    tick;
    req_valid = 2'b10;
    #1;
    chk("t4_addu_result", {rsp_out[31:0], 29'd0, rsp_flags[2:0]}, {32'd0, 29'd0, 3'b110});
    chk("t4_req1_blocked", req_ready, 2'b00);
    tick;
    set_req(0, OP_ADD, 32'd0, 32'd0, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("t4_owner_grant", req_ready, 2'b01);
    tick;
    req_valid = 2'b10;
    #1;
    chk("t4_add_result", {rsp_out[31:0], 29'd0, rsp_flags[2:0]}, {32'd0, 29'd0, 3'b100});
    chk("t4_req1_after_unlock", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    tick;

    // T5: owner goes idle, forced release after LOCK_MAX cycles
    set_req(0, OP_ADD, 32'd1, 32'd2, 1'b1);
    req_valid = 2'b11;
    #1;
    chk("t5_lock_grant", req_ready, 2'b01);
    tick;
    req_valid = 2'b10;
    blocked = 0;
    pulses  = 0;
    #1;
    while (req_ready != 2'b10 && blocked < 40) begin
      if (lock_timeout) pulses++;
      blocked++;
      tick;
    end
    chk("t5_blocked_cycles", blocked, 16);
    chk("t5_no_early_pulse", pulses, 0);
    chk("t5_pulse_at_release", lock_timeout, 1'b1);
    tick;
    chk("t5_pulse_once", lock_timeout, 1'b0);

    // T6: reset while locked with both slots full
    rsp_ready = 2'b00;
    set_req(0, OP_ADD, 32'd3, 32'd4, 1'b1);
    req_valid = 2'b11;
    #1;
    chk("t6_lock_grant", req_ready, 2'b01);
    tick;
    chk("t6_slots_full", rsp_valid, 2'b11);
    rst = 1'b1;
    #1;
    chk("t6_rst_no_grant", req_ready, 2'b00);
    tick;
    chk("t6_rsp_valid", rsp_valid, 2'b00);
    chk("t6_rsp_out", rsp_out, 64'd0);
    chk("t6_flags_timeout", {rsp_flags, lock_timeout}, 7'd0);
    rst = 1'b0;
    req_lock = 2'b00;
    #1;
    chk("t6_first_grant_req0", req_ready, 2'b01);
    tick;
    chk("t6_rsp_after", {rsp_valid, rsp_out[31:0]}, {2'b01, 32'd7});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
